// File: rtl/decode_stage_hz.sv
// MIPS decode stage: register file, immediate extension, load-use hazard
// detection and the ID/EX pipeline register.
module decode_stage_hz #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int CTRL_W  = 20,
  parameter int BYPASS  = 1,
  localparam int ADDR_W = $clog2(REG_CNT)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       InstrIn,
  input  logic              InstrValidIn,
  input  logic [31:0]       PcPlus4In,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic              WbEnIn,
  input  logic [ADDR_W-1:0] WbRegIn,
  input  logic [DATA_W-1:0] WbDataIn,
  input  logic              ExMemReadIn,
  input  logic [ADDR_W-1:0] ExRtIn,
  input  logic              FlushIn,
  output logic              StallOut,
  output logic              ValidOut,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [DATA_W-1:0] Rs1DataOut,
  output logic [DATA_W-1:0] Rs2DataOut,
  output logic [DATA_W-1:0] ImmOut,
  output logic [ADDR_W-1:0] RsOut,
  output logic [ADDR_W-1:0] RtOut,
  output logic [ADDR_W-1:0] RdOut,
  output logic [31:0]       PcPlus4Out,
  output logic [15:0]       StallCntOut,
  output logic [DATA_W-1:0] V0Out,
  output logic [DATA_W-1:0] V1Out
);

  logic [DATA_W-1:0] rf [REG_CNT];

  logic [ADDR_W-1:0] rsIdx, rtIdx, rdIdx;
  logic [5:0]        opcode;
  logic [DATA_W-1:0] rsData, rtData, immExt;
  logic              hz, bubble;

  assign rsIdx  = InstrIn[21 +: ADDR_W];
  assign rtIdx  = InstrIn[16 +: ADDR_W];
  assign rdIdx  = InstrIn[11 +: ADDR_W];
  assign opcode = InstrIn[31:26];

  // Index 0 is forced last so neither storage nor bypass can make r0 nonzero.
  always_comb begin
    rsData = rf[rsIdx];
    rtData = rf[rtIdx];
    if (BYPASS != 0 && WbEnIn && WbRegIn == rsIdx) rsData = WbDataIn;
    if (BYPASS != 0 && WbEnIn && WbRegIn == rtIdx) rtData = WbDataIn;
    if (rsIdx == '0) rsData = '0;
    if (rtIdx == '0) rtData = '0;
  end

  // andi/ori/xori take a zero-extended immediate.
  always_comb begin
    if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
      immExt = DATA_W'(InstrIn[15:0]);
    else
      immExt = DATA_W'($signed(InstrIn[15:0]));
  end

  assign hz       = InstrValidIn & ExMemReadIn & (ExRtIn != '0) &
                    ((ExRtIn == rsIdx) | (ExRtIn == rtIdx));
  assign StallOut = hz & ~FlushIn;
  assign bubble   = FlushIn | hz;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
    end else if (WbEnIn && WbRegIn != '0) begin
      rf[WbRegIn] <= WbDataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ValidOut   <= 1'b0;
      CtrlOut    <= '0;
      Rs1DataOut <= '0;
      Rs2DataOut <= '0;
      ImmOut     <= '0;
      RsOut      <= '0;
      RtOut      <= '0;
      RdOut      <= '0;
      PcPlus4Out <= '0;
    end else begin
      ValidOut   <= InstrValidIn & ~bubble;
      CtrlOut    <= (InstrValidIn && !bubble) ? CtrlIn : '0;
      Rs1DataOut <= rsData;
      Rs2DataOut <= rtData;
      ImmOut     <= immExt;
      RsOut      <= rsIdx;
      RtOut      <= rtIdx;
      RdOut      <= rdIdx;
      PcPlus4Out <= PcPlus4In;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      StallCntOut <= '0;
    else if (StallOut && StallCntOut != 16'hFFFF)
      StallCntOut <= StallCntOut + 16'd1;
  end

  assign V0Out = rf[2];
  assign V1Out = rf[3];

endmodule
